mshr_mem_ctrl: RTL and testbench

Sequencer between the D-cache MSHR issue queue and the shared memory bus. It takes the entry at the MSHR issue head and drives it onto the bus as a BUS_LOAD or BUS_STORE command, retrying until memory accepts it. It acknowledges the MSHR once the command is accepted and keeps a table of outstanding loads indexed by memory tag. When load data returns, it emits a registered fill toward the cache refill path.

---
 rtl/mshr_mem_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mshr_mem_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mshr_mem_ctrl.sv
// MSHR-to-memory-bus sequencer: issues the MSHR head as a bus load/store and tracks in-flight loads by memory tag.
// Optional build macro MSHR_MEM_CTRL_STATS_EN adds the saturating counters retry_cnt_o and load_cnt_o.
package mshr_mem_ctrl_pkg;
    typedef enum logic [1:0] {NONE = 2'd0, GET_S = 2'd1, GET_M = 2'd2, PUT_M = 2'd3} message_t;
    typedef enum logic [1:0] {BUS_NONE = 2'd0, BUS_LOAD = 2'd1, BUS_STORE = 2'd2} bus_cmd_t;
endpackage

module mshr_mem_ctrl
    import mshr_mem_ctrl_pkg::*;
#(
    parameter int MEM_TAG_W  = 4,
    parameter int MSHR_IDX_W = 3,
    parameter int TAG_W      = 7,
    parameter int IDX_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mshr_iss_en_i,
    input  logic [TAG_W-1:0]      mshr_iss_tag_i,
    input  logic [IDX_W-1:0]      mshr_iss_idx_i,
    input  logic [63:0]           mshr_iss_data_i,
    input  message_t              mshr_iss_message_i,
    input  logic [MSHR_IDX_W-1:0] mshr_iss_head_i,
    output logic                  mshr_iss_ack_o,
    input  logic                  mem_gnt_i,
    output bus_cmd_t              proc2mem_command_o,
    output logic [63:0]           proc2mem_addr_o,
    output logic [63:0]           proc2mem_data_o,
    input  logic [MEM_TAG_W-1:0]  mem2proc_response_i,
    input  logic [MEM_TAG_W-1:0]  mem2proc_tag_i,
    input  logic [63:0]           mem2proc_data_i,
    output logic                  fill_vld_o,
    output logic [TAG_W-1:0]      fill_tag_o,
    output logic [IDX_W-1:0]      fill_idx_o,
    output logic [63:0]           fill_data_o,
    output message_t              fill_message_o,
    output logic [MSHR_IDX_W-1:0] fill_mshr_idx_o,
    output logic [MEM_TAG_W-1:0]  outstanding_o
`ifdef MSHR_MEM_CTRL_STATS_EN
    ,
    output logic [31:0]           retry_cnt_o,
    output logic [31:0]           load_cnt_o
`endif
);

    localparam int DEPTH = 1 << MEM_TAG_W;

    typedef enum logic {IDLE, ISSUE} state_t;

    typedef struct packed {
        logic                  vld;
        logic [TAG_W-1:0]      tag;
        logic [IDX_W-1:0]      idx;
        message_t              message;
        logic [MSHR_IDX_W-1:0] head;
    } entry_t;

    state_t                state_q;
    logic [TAG_W-1:0]      cmd_tag_q;
    logic [IDX_W-1:0]      cmd_idx_q;
    logic [63:0]           cmd_data_q;
    message_t              cmd_msg_q;
    logic [MSHR_IDX_W-1:0] cmd_head_q;

    entry_t                tag_tbl_q [DEPTH];
    entry_t                fill_ent_q;
    logic [63:0]           fill_data_q;
    logic [MEM_TAG_W-1:0]  count_q, count_d;

    logic full, accept, alloc, ret_hit, take_head;

    always_comb begin
        full      = (count_q == {MEM_TAG_W{1'b1}});
        accept    = !rst && (state_q == ISSUE) && mem_gnt_i && (mem2proc_response_i != '0);
        alloc     = accept && (cmd_msg_q != PUT_M);
        ret_hit   = (mem2proc_tag_i != '0) && tag_tbl_q[mem2proc_tag_i].vld;
        take_head = mshr_iss_en_i && (mshr_iss_message_i != NONE) &&
                    ((mshr_iss_message_i == PUT_M) || !full);
        // A same-cycle return and allocation cancel out in the count.
        count_d = count_q;
        if (alloc && !ret_hit)
            count_d = count_q + MEM_TAG_W'(1);
        else if (ret_hit && !alloc)
            count_d = count_q - MEM_TAG_W'(1);
    end

    always_comb begin
        proc2mem_command_o = BUS_NONE;
        if (!rst && (state_q == ISSUE) && mem_gnt_i)
            proc2mem_command_o = (cmd_msg_q == PUT_M) ? BUS_STORE : BUS_LOAD;
    end

    assign proc2mem_addr_o = 64'({cmd_tag_q, cmd_idx_q, 3'b000});
    assign proc2mem_data_o = cmd_data_q;
    assign mshr_iss_ack_o  = accept ||
                             (!rst && (state_q == IDLE) && mshr_iss_en_i && (mshr_iss_message_i == NONE));
    assign outstanding_o   = count_q;

    assign fill_vld_o      = fill_ent_q.vld;
    assign fill_tag_o      = fill_ent_q.tag;
    assign fill_idx_o      = fill_ent_q.idx;
    assign fill_message_o  = fill_ent_q.message;
    assign fill_mshr_idx_o = fill_ent_q.head;
    assign fill_data_o     = fill_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_tag_q  <= '0;
            cmd_idx_q  <= '0;
            cmd_data_q <= '0;
            cmd_msg_q  <= NONE;
            cmd_head_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (take_head) begin
                    cmd_tag_q  <= mshr_iss_tag_i;
                    cmd_idx_q  <= mshr_iss_idx_i;
                    cmd_data_q <= mshr_iss_data_i;
                    cmd_msg_q  <= mshr_iss_message_i;
                    cmd_head_q <= mshr_iss_head_i;
                    state_q    <= ISSUE;
                end
                ISSUE: if (accept) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the tag table is reset so responses to abandoned commands find no valid entry.
            for (int i = 0; i < DEPTH; i++) tag_tbl_q[i] <= '0;
            fill_ent_q  <= '0;
            fill_data_q <= '0;
            count_q     <= '0;
        end else begin
            count_q        <= count_d;
            fill_ent_q.vld <= ret_hit;
            if (ret_hit) begin
                fill_ent_q.tag     <= tag_tbl_q[mem2proc_tag_i].tag;
                fill_ent_q.idx     <= tag_tbl_q[mem2proc_tag_i].idx;
                fill_ent_q.message <= tag_tbl_q[mem2proc_tag_i].message;
                fill_ent_q.head    <= tag_tbl_q[mem2proc_tag_i].head;
                fill_data_q        <= mem2proc_data_i;
                tag_tbl_q[mem2proc_tag_i].vld <= 1'b0;
            end
            // Later write wins, so a same-tag allocation leaves the entry valid.
            if (alloc)
                tag_tbl_q[mem2proc_response_i] <= '{vld: 1'b1, tag: cmd_tag_q, idx: cmd_idx_q,
                                                    message: cmd_msg_q, head: cmd_head_q};
        end
    end

`ifdef MSHR_MEM_CTRL_STATS_EN
    logic [31:0] retry_cnt_q, load_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            retry_cnt_q <= '0;
            load_cnt_q  <= '0;
        end else begin
            if ((state_q == ISSUE) && !accept && (retry_cnt_q != '1))
                retry_cnt_q <= retry_cnt_q + 32'd1;
            if (alloc && (load_cnt_q != '1))
                load_cnt_q <= load_cnt_q + 32'd1;
        end
    end

    assign retry_cnt_o = retry_cnt_q;
    assign load_cnt_o  = load_cnt_q;
`endif

endmodule

// File: tb/tb_mshr_mem_ctrl.sv
// Directed self-checking bench for mshr_mem_ctrl: load, store, retry, full table, tag collision, reset, NONE ack.
module tb_mshr_mem_ctrl;
    import mshr_mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_en;
    logic [6:0]  iss_tag;
    logic [2:0]  iss_idx;
    logic [63:0] iss_data;
    message_t    iss_msg;
    logic [2:0]  iss_head;
    logic        ack;
    logic        gnt;
    bus_cmd_t    cmd;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [3:0]  resp;
    logic [3:0]  rtag;
    logic [63:0] rdata;
    logic        fill_vld;
    logic [6:0]  fill_tag;
    logic [2:0]  fill_idx;
    logic [63:0] fill_data;
    message_t    fill_msg;
    logic [2:0]  fill_mshr;
    logic [3:0]  outstanding;
`ifdef MSHR_MEM_CTRL_STATS_EN
    logic [31:0] retry_cnt;
    logic [31:0] load_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    mshr_mem_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .mshr_iss_en_i       (iss_en),
        .mshr_iss_tag_i      (iss_tag),
        .mshr_iss_idx_i      (iss_idx),
        .mshr_iss_data_i     (iss_data),
        .mshr_iss_message_i  (iss_msg),
        .mshr_iss_head_i     (iss_head),
        .mshr_iss_ack_o      (ack),
        .mem_gnt_i           (gnt),
        .proc2mem_command_o  (cmd),
        .proc2mem_addr_o     (addr),
        .proc2mem_data_o     (wdata),
        .mem2proc_response_i (resp),
        .mem2proc_tag_i      (rtag),
        .mem2proc_data_i     (rdata),
        .fill_vld_o          (fill_vld),
        .fill_tag_o          (fill_tag),
        .fill_idx_o          (fill_idx),
        .fill_data_o         (fill_data),
        .fill_message_o      (fill_msg),
        .fill_mshr_idx_o     (fill_mshr),
        .outstanding_o       (outstanding)
`ifdef MSHR_MEM_CTRL_STATS_EN
        ,
        .retry_cnt_o         (retry_cnt),
        .load_cnt_o          (load_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_head(input message_t m, input logic [6:0] t, input logic [2:0] i,
                            input logic [63:0] d, input logic [2:0] h);
        iss_en   = 1'b1;
        iss_msg  = m;
        iss_tag  = t;
        iss_idx  = i;
        iss_data = d;
        iss_head = h;
    endtask

    initial begin
        rst = 1'b1; iss_en = 1'b0; iss_tag = '0; iss_idx = '0; iss_data = '0;
        iss_msg = NONE; iss_head = '0; gnt = 1'b0; resp = '0; rtag = '0; rdata = '0;

        // Reset state
        tick(); settle();
        check("rst_cmd", cmd, BUS_NONE);
        check("rst_ack", ack, 1'b0);
        tick(); rst = 1'b0; settle();
        check("rst_out", outstanding, 4'd0);
        check("rst_fill_vld", fill_vld, 1'b0);
        check("rst_fill_data", fill_data, 64'h0);
        check("rst_addr", addr, 64'h0);

        // Basic load: {7'h12, 3'h5, 3'b000} = 0x4A8
        set_head(GET_S, 7'h12, 3'h5, 64'h0, 3'd2); settle();
        check("ld_idle_cmd", cmd, BUS_NONE);
        check("ld_idle_ack", ack, 1'b0);
        tick(); gnt = 1'b1; resp = 4'd3; settle();
        check("ld_cmd", cmd, BUS_LOAD);
        check("ld_addr", addr, 64'h4A8);
        check("ld_ack", ack, 1'b1);
        tick(); iss_en = 1'b0; gnt = 1'b0; resp = '0; settle();
        check("ld_ack_once", ack, 1'b0);
        check("ld_out1", outstanding, 4'd1);
        check("ld_cmd_done", cmd, BUS_NONE);
        tick(); tick(); tick();
        rtag = 4'd3; rdata = 64'hDEAD_BEEF; settle();
        check("ld_fill_early", fill_vld, 1'b0);
        tick(); rtag = '0; rdata = '0; settle();
        check("ld_fill_vld", fill_vld, 1'b1);
        check("ld_fill_tag", fill_tag, 7'h12);
        check("ld_fill_idx", fill_idx, 3'h5);
        check("ld_fill_data", fill_data, 64'hDEAD_BEEF);
        check("ld_fill_msg", fill_msg, GET_S);
        check("ld_fill_mshr", fill_mshr, 3'd2);
        check("ld_out0", outstanding, 4'd0);
        tick(); settle();
        check("ld_fill_pulse", fill_vld, 1'b0);

        // Store with two ungranted cycles: {7'h01, 3'h0, 3'b000} = 0x40
        set_head(PUT_M, 7'h01, 3'h0, 64'hA5, 3'd1);
        tick(); settle();
        check("st_nognt0_cmd", cmd, BUS_NONE);
        check("st_nognt0_ack", ack, 1'b0);
        tick(); settle();
        check("st_nognt1_cmd", cmd, BUS_NONE);
        tick(); gnt = 1'b1; resp = 4'd5; settle();
        check("st_cmd", cmd, BUS_STORE);
        check("st_data", wdata, 64'hA5);
        check("st_addr", addr, 64'h40);
        check("st_ack", ack, 1'b1);
        tick(); iss_en = 1'b0; gnt = 1'b0; resp = '0; rtag = 4'd5; settle();
        check("st_out", outstanding, 4'd0);
        tick(); rtag = '0; settle();
        check("st_no_fill", fill_vld, 1'b0);

        // Retry: three rejections then accept with tag 9; {7'h7F, 3'h7, 3'b000} = 0x1FF8
        set_head(GET_M, 7'h7F, 3'h7, 64'h0, 3'd3);
        tick(); gnt = 1'b1; resp = '0;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("rt_cmd", cmd, BUS_LOAD);
            check("rt_addr", addr, 64'h1FF8);
            check("rt_ack", ack, 1'b0);
            tick();
        end
        resp = 4'd9; settle();
        check("rt_acc_cmd", cmd, BUS_LOAD);
        check("rt_acc_addr", addr, 64'h1FF8);
        check("rt_acc_ack", ack, 1'b1);
        tick(); iss_en = 1'b0; gnt = 1'b0; resp = '0; settle();
        check("rt_ack_once", ack, 1'b0);
        check("rt_out", outstanding, 4'd1);
`ifdef MSHR_MEM_CTRL_STATS_EN
        // Two ungranted store cycles plus three rejected load cycles.
        check("rt_retry_cnt", retry_cnt, 32'd5);
        check("rt_load_cnt", load_cnt, 32'd2);
`endif
        rtag = 4'd9;
        tick(); rtag = '0; settle();
        check("rt_fill_vld", fill_vld, 1'b1);
        check("rt_fill_tag", fill_tag, 7'h7F);
        check("rt_fill_msg", fill_msg, GET_M);
        check("rt_fill_mshr", fill_mshr, 3'd3);
        check("rt_out0", outstanding, 4'd0);

        // Same-tag collision on tag 4
        set_head(GET_S, 7'h21, 3'h1, 64'h0, 3'd4);
        tick(); gnt = 1'b1; resp = 4'd4; settle();
        check("co_first_ack", ack, 1'b1);
        tick(); gnt = 1'b0; resp = '0;
        set_head(GET_M, 7'h42, 3'h2, 64'h0, 3'd5); settle();
        check("co_out1", outstanding, 4'd1);
        tick(); gnt = 1'b1; resp = 4'd4; rtag = 4'd4; rdata = 64'h1111; settle();
        check("co_ack", ack, 1'b1);
        tick(); iss_en = 1'b0; gnt = 1'b0; resp = '0; rtag = '0; settle();
        check("co_fill_vld", fill_vld, 1'b1);
        check("co_fill_tag", fill_tag, 7'h21);
        check("co_fill_msg", fill_msg, GET_S);
        check("co_fill_mshr", fill_mshr, 3'd4);
        check("co_fill_data", fill_data, 64'h1111);
        check("co_out_same", outstanding, 4'd1);
        rtag = 4'd4; rdata = 64'h2222;
        tick(); rtag = '0; settle();
        check("co_new_vld", fill_vld, 1'b1);
        check("co_new_tag", fill_tag, 7'h42);
        check("co_new_msg", fill_msg, GET_M);
        check("co_new_mshr", fill_mshr, 3'd5);
        check("co_out0", outstanding, 4'd0);

        // Full table: 15 loads on tags 1..15
        for (int i = 1; i <= 15; i++) begin
            set_head(GET_S, 7'(i), 3'(i), 64'h0, 3'(i)); gnt = 1'b0; resp = '0;
            tick(); gnt = 1'b1; resp = 4'(i); settle();
            check("fu_ack", ack, 1'b1);
            tick();
        end
        iss_en = 1'b0; gnt = 1'b0; resp = '0; settle();
        check("fu_out15", outstanding, 4'd15);
        set_head(GET_S, 7'h55, 3'h3, 64'h0, 3'd0); gnt = 1'b1; resp = 4'd6;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("fu_stall_cmd", cmd, BUS_NONE);
            check("fu_stall_ack", ack, 1'b0);
            tick();
        end
        rtag = 4'd2; rdata = 64'h33; settle();
        check("fu_ret_cmd", cmd, BUS_NONE);
        tick(); rtag = '0; settle();
        check("fu_ret_fill", fill_vld, 1'b1);
        check("fu_out14", outstanding, 4'd14);
        check("fu_r1_cmd", cmd, BUS_NONE);
        resp = 4'd2;
        tick(); settle();
        // {7'h55, 3'h3, 3'b000} = 0x1558
        check("fu_go_cmd", cmd, BUS_LOAD);
        check("fu_go_addr", addr, 64'h1558);
        check("fu_go_ack", ack, 1'b1);
        tick();
        set_head(PUT_M, 7'h66, 3'h6, 64'hFEED, 3'd1); resp = 4'd7; settle();
        check("fu_out15b", outstanding, 4'd15);
        tick(); settle();
        check("fu_put_cmd", cmd, BUS_STORE);
        check("fu_put_data", wdata, 64'hFEED);
        check("fu_put_ack", ack, 1'b1);
        tick(); iss_en = 1'b0; gnt = 1'b0; resp = '0; settle();
        check("fu_put_out", outstanding, 4'd15);

        // Reset while in ISSUE with loads outstanding
        set_head(GET_S, 7'h10, 3'h0, 64'h0, 3'd6);
        tick(); rst = 1'b1; gnt = 1'b1; resp = 4'd3; settle();
        check("rs_ack", ack, 1'b0);
        check("rs_cmd", cmd, BUS_NONE);
        tick(); rst = 1'b0; iss_en = 1'b0; settle();
        check("rs_out", outstanding, 4'd0);
        check("rs_idle_cmd", cmd, BUS_NONE);
        check("rs_idle_ack", ack, 1'b0);
        rtag = 4'd1;
        tick(); rtag = 4'd2; settle();
        check("rs_no_fill1", fill_vld, 1'b0);
        tick(); rtag = '0; settle();
        check("rs_no_fill2", fill_vld, 1'b0);
        check("rs_out_after", outstanding, 4'd0);
        gnt = 1'b0; resp = '0;

        // NONE at head is acked without bus traffic
        iss_en = 1'b1; iss_msg = NONE; settle();
        check("none_ack", ack, 1'b1);
        check("none_cmd", cmd, BUS_NONE);
        tick(); iss_en = 1'b0; gnt = 1'b1; resp = 4'd1; settle();
        check("none_stay_idle", cmd, BUS_NONE);
        check("none_ack_off", ack, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
